instr_fetch_unit: RTL and testbench

- Fetch stage plus IF/ID pipeline register.
- Drives a program counter and issues word requests to instruction memory using a req/ack handshake.
- Registers the fetched word as IR_o. IR_o feeds the decode-stage immediate sign-extension logic and the register-file address fields.
- Handles decode stalls with a one-entry skid buffer, and handles branch/jump redirects, including squashing an in-flight request.

---
 rtl/instr_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage plus IF/ID pipeline register. Drives a program counter, issues
// one word request at a time to instruction memory and registers the returned
// word as IR_o for decode. A one-entry skid buffer absorbs the word that
// lands while decode is stalled. Taken branches/jumps arrive as a one-cycle
// redirect; a request still in flight at that point is completed and its
// data thrown away (DROP state).
//
// Optional feature: define IFETCH_JUMP_PREDECODE_EN to follow J-format words
// (IR[31:28] == ALU_J) at fetch time: the next fetch address becomes
// pc + sign_extend(IR[27:0]) instead of pc + PC_STEP.
//
// Handshake (memory side): imem_req_o is a level. While it is high,
// imem_addr_o is stable; the request completes on the first rising edge at
// which imem_ack_i is high, and imem_rdata_i is valid in that cycle. At most
// one request is outstanding. imem_ack_i while imem_req_o is low is ignored.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   stall_i        decode cannot accept; IR_o/pc_o/valid_o hold
//   redirect_i     one-cycle taken branch/jump pulse
//   redirect_pc_i  new fetch address, valid with redirect_i
//   imem_req_o     fetch request (level)
//   imem_addr_o    fetch byte address
//   imem_ack_i     request complete this cycle
//   imem_rdata_i   fetched instruction word
//   IR_o           registered instruction to decode
//   pc_o           address of IR_o
//   valid_o        IR_o holds a real instruction
//   dbg_state_o    current FSM state (IDLE=0, FETCH=1, FULL=2, DROP=3)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IR_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;             // address of the current/next request
  logic [31:0] r_target, w_target_nxt;     // redirect target parked during DROP
  logic [31:0] r_ir, w_ir_nxt;
  logic [31:0] r_pc_out, w_pc_out_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [31:0] r_skid_ir, w_skid_ir_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;

  logic        w_req;
  logic        w_ack;
  logic        w_word;                     // a real word arrives this cycle
  logic [31:0] w_pc_seq;                   // fetch address following this word

  assign w_req  = (r_state == S_FETCH) || (r_state == S_DROP);
  assign w_ack  = w_req && imem_ack_i;
  assign w_word = (r_state == S_FETCH) && imem_ack_i;

`ifdef IFETCH_JUMP_PREDECODE_EN
  localparam logic [3:0] ALU_J = 4'hA;
  logic w_is_jump;
  assign w_is_jump = (imem_rdata_i[31:28] == ALU_J);
  assign w_pc_seq  = w_is_jump ? (r_pc + {{4{imem_rdata_i[27]}}, imem_rdata_i[27:0]})
                               : (r_pc + PC_STEP);
`else
  assign w_pc_seq  = r_pc + PC_STEP;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_target     <= RESET_PC;
      r_ir         <= NOP_IR;
      r_pc_out     <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_ir    <= NOP_IR;
      r_skid_pc    <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_target     <= w_target_nxt;
      r_ir         <= w_ir_nxt;
      r_pc_out     <= w_pc_out_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_ir    <= w_skid_ir_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_target_nxt     = r_target;
    w_ir_nxt         = r_ir;
    w_pc_out_nxt     = r_pc_out;
    w_valid_nxt      = r_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_ir_nxt    = r_skid_ir;
    w_skid_pc_nxt    = r_skid_pc;

    if (redirect_i) begin
      // Redirect beats stall: everything younger than the branch is flushed.
      w_valid_nxt      = 1'b0;
      w_ir_nxt         = NOP_IR;
      w_skid_valid_nxt = 1'b0;
      if (w_req && !imem_ack_i) begin
        // Request still open: keep the old address on the bus until its
        // ack, remember where to go afterwards.
        w_state_nxt  = S_DROP;
        w_target_nxt = redirect_pc_i;
      end else begin
        // Nothing open, or the ack lands now and is simply discarded.
        w_state_nxt = S_FETCH;
        w_pc_nxt    = redirect_pc_i;
      end
    end else begin
      if (w_word) begin
        w_pc_nxt = w_pc_seq;
      end

      if (!stall_i) begin
        if (r_skid_valid) begin
          w_ir_nxt         = r_skid_ir;
          w_pc_out_nxt     = r_skid_pc;
          w_valid_nxt      = 1'b1;
          w_skid_valid_nxt = w_word;
          if (w_word) begin
            w_skid_ir_nxt = imem_rdata_i;
            w_skid_pc_nxt = r_pc;
          end
        end else if (w_word) begin
          w_ir_nxt     = imem_rdata_i;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
        end else begin
          w_ir_nxt    = NOP_IR;
          w_valid_nxt = 1'b0;
        end
      end else if (w_word) begin
        // Decode is holding IR_o; park the new word. The skid is always
        // empty here because req is low while it is full.
        w_skid_valid_nxt = 1'b1;
        w_skid_ir_nxt    = imem_rdata_i;
        w_skid_pc_nxt    = r_pc;
      end

      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (w_skid_valid_nxt) w_state_nxt = S_FULL;
        S_FULL:  if (!w_skid_valid_nxt) w_state_nxt = S_FETCH;
        S_DROP: begin
          if (w_ack) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = r_target;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign IR_o        = r_ir;
  assign pc_o        = r_pc_out;
  assign valid_o     = r_valid;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A behavioural memory answers each
// request after a programmable number of cycles. A reference model tracks the
// program-order address of the next instruction decode should accept and the
// word stored there; every accepted instruction, every stall hold, every
// post-redirect flush and the request address stability are checked, plus
// directed timing checks taken from the expected behaviour.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_IR   = 32'h0000_0000;
  localparam logic [3:0]  ALU_J    = 4'hA;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] IR_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_accept = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_IR   (NOP_IR),
    .PC_STEP  (32'd4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .IR_o          (IR_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .dbg_state_o   (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  logic jump_mode = 1'b0;   // places a J word at 0x10

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jump_mode && a == 32'h10) return {ALU_J, 28'hFFFFFF0};
    return {4'h1, 28'((a >> 2) + 32'd1)};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
`ifdef IFETCH_JUMP_PREDECODE_EN
    if (w[31:28] == ALU_J) return pc + {{4{w[27]}}, w[27:0]};
`endif
    return pc + 32'd4;
  endfunction

  // ---------------- behavioural memory ----------------
  int   mem_lat  = 1;
  int   mem_wait = 0;
  logic stray_en = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rst_i || !imem_req_o) begin
      mem_wait = 0;
      imem_ack_i = stray_en && ($urandom_range(0, 9) == 0);
      imem_rdata_i = $urandom;
    end else begin
      if (imem_ack_i) mem_wait = 0;   // previous ack completed that request
      if (mem_wait + 1 >= mem_lat) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
      end else begin
        imem_ack_i = 1'b0;
        mem_wait++;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  logic [31:0] exp_pc = RESET_PC;
  logic        p_rst = 1'b1, p_stall = 1'b0, p_redir = 1'b0;
  logic        p_valid = 1'b0, p_req = 1'b0, p_ack = 1'b0;
  logic [31:0] p_ir = '0, p_pc = '0, p_addr = '0;

  always @(negedge clk) begin
    if (!p_rst) begin
      if (p_redir) begin
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ir", IR_o, NOP_IR);
      end else if (p_stall) begin
        chk("hold_valid", 32'(valid_o), 32'(p_valid));
        chk("hold_ir", IR_o, p_ir);
        chk("hold_pc", pc_o, p_pc);
      end
      if (p_req && !p_ack && imem_req_o) chk("addr_stable", imem_addr_o, p_addr);
    end
    if (!valid_o) chk("nop_when_invalid", IR_o, NOP_IR);

    if (rst_i) begin
      exp_pc = RESET_PC;
    end else begin
      if (valid_o && !stall_i) begin
        chk("accept_pc", pc_o, exp_pc);
        chk("accept_ir", IR_o, mem_word(exp_pc));
        n_accept++;
        exp_pc = next_pc(exp_pc, mem_word(exp_pc));
      end
      if (redirect_i) exp_pc = redirect_pc_i;
    end

    p_rst = rst_i;  p_stall = stall_i;  p_redir = redirect_i;
    p_valid = valid_o;  p_ir = IR_o;  p_pc = pc_o;
    p_req = imem_req_o;  p_ack = imem_ack_i;  p_addr = imem_addr_o;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the last reset edge; the next step()
  // lands just after the first edge with reset low.
  task automatic reset_dut(input int lat);
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; mem_lat = lat;
    step();
    step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ir", IR_o, NOP_IR);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    rst_i = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int vcount;
    int acc0;

    // Zero-wait memory: words at 0x0 and 0x4, one instruction per cycle.
    reset_dut(1);
    step();  // E1
    chk("zw_req", 32'(imem_req_o), 32'd1);
    chk("zw_addr0", imem_addr_o, 32'h0);
    chk("zw_valid_e1", 32'(valid_o), 32'd0);
    step();  // E2
    chk("zw_ir0", IR_o, 32'h1000_0001);
    chk("zw_pc0", pc_o, 32'h0);
    chk("zw_valid0", 32'(valid_o), 32'd1);
    chk("zw_addr1", imem_addr_o, 32'h4);
    step();  // E3
    chk("zw_ir1", IR_o, 32'h1000_0002);
    chk("zw_pc1", pc_o, 32'h4);
    chk("zw_valid1", 32'(valid_o), 32'd1);
    repeat (6) step();

    // Three-cycle memory: valid pulses once every third cycle.
    reset_dut(3);
    vcount = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (valid_o) vcount++;
    end
    chk("slow_valid_count", 32'(vcount), 32'd9);

    // Stall for 4 cycles while the next word completes.
    reset_dut(1);
    step();
    step();  // E2: word 0 valid
    stall_i = 1'b1;
    step();  // E3: word 4 into skid
    chk("stall_req_drop", 32'(imem_req_o), 32'd0);
    chk("stall_pc_hold", pc_o, 32'h0);
    step();
    step();
    step();  // E6
    stall_i = 1'b0;
    step();  // E7: skid word out
    chk("stall_skid_pc", pc_o, 32'h4);
    chk("stall_skid_valid", 32'(valid_o), 32'd1);
    chk("stall_refetch_addr", imem_addr_o, 32'h8);
    step();  // E8
    chk("stall_next_pc", pc_o, 32'h8);

    // Redirect to 0x200 while the request to 0x8 is outstanding.
    reset_dut(3);
    repeat (7) step();  // E7: word 4 delivered, request to 0x8 open
    chk("drop_pre_pc", pc_o, 32'h4);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();  // E8
    redirect_i = 1'b0;
    chk("drop_valid_e8", 32'(valid_o), 32'd0);
    step();  // E9
    chk("drop_old_addr", imem_addr_o, 32'h8);
    chk("drop_req", 32'(imem_req_o), 32'd1);
    step();  // E10: 0x8 data discarded
    chk("drop_new_addr", imem_addr_o, 32'h200);
    chk("drop_valid_e10", 32'(valid_o), 32'd0);
    step();
    chk("drop_valid_e11", 32'(valid_o), 32'd0);
    step();
    chk("drop_valid_e12", 32'(valid_o), 32'd0);
    step();  // E13
    chk("drop_tgt_pc", pc_o, 32'h200);
    chk("drop_tgt_ir", IR_o, mem_word(32'h200));

    // Redirect in the same cycle as an ack, with stall high.
    reset_dut(1);
    step();
    step();  // E2
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
    step();  // E3
    redirect_i = 1'b0;
    chk("rack_valid", 32'(valid_o), 32'd0);
    chk("rack_ir", IR_o, NOP_IR);
    chk("rack_addr", imem_addr_o, 32'h300);
    step();  // E4: 0x300 parked
    chk("rack_full_req", 32'(imem_req_o), 32'd0);
    stall_i = 1'b0;
    step();  // E5
    chk("rack_first_pc", pc_o, 32'h300);
    chk("rack_first_valid", 32'(valid_o), 32'd1);

    // J word at 0x10 with offset -16.
    jump_mode = 1'b1;
    reset_dut(1);
    repeat (6) step();  // E6: 0x10 acked
`ifdef IFETCH_JUMP_PREDECODE_EN
    chk("jump_next_addr", imem_addr_o, 32'h0);
`else
    chk("jump_next_addr", imem_addr_o, 32'h14);
`endif
    repeat (4) step();

    // Random traffic: latency, stalls, redirects (some near the wrap point),
    // stray acks while idle.
    jump_mode = 1'b0;
    reset_dut(1);
    stray_en = 1'b1;
    acc0 = n_accept;
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 4);
      stall_i = ($urandom_range(0, 99) < 30);
      redirect_i = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0)
        redirect_pc_i = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      else
        redirect_pc_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rst_i = ($urandom_range(0, 399) == 0);
      step();
    end
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; stray_en = 1'b0;
    repeat (10) step();
    chk("random_progress", 32'(n_accept - acc0 > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
